// File: rtl/btn_pkg.sv
// Shared constants for the button front-end: repeat-FSM encoding and board timing defaults.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
package btn_pkg;

    // Repeat FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    // Default timing for the 50 MHz board clock
    localparam int DEBOUNCE_DEF     = 3000;        // 60 us of stable input
    localparam int REPEAT_DELAY_DEF = 12_000_000;  // ~240 ms before the first repeat
    localparam int REPEAT_RATE_DEF  = 3_000_000;   // ~60 ms between repeats

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, stable-time debouncer, edge pulses, auto-repeat FSM.
// Latency: raw edge to btn_level = DEBOUNCE+2 edges; btn_press/btn_out one edge after btn_level.
// Backpressure: none; pulses are fire-and-forget, one cycle wide.
// Ports: clk, reset (async, active-low), btn_in (raw async level),
//        btn_level (debounced), btn_press / btn_release (edge pulses), btn_out (press + repeat pulses).
module btn_channel
    import btn_pkg::*;
#(
    parameter int   CNT_W        = 25,
    parameter int   DEBOUNCE     = DEBOUNCE_DEF,
    parameter int   REPEAT_DELAY = REPEAT_DELAY_DEF,
    parameter int   REPEAT_RATE  = REPEAT_RATE_DEF,
    parameter logic repeat_en    = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_out
);

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_RATE - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] db_cnt;
    logic             level_d;
    logic [1:0]       state;
    logic [CNT_W-1:0] rpt_cnt;
    logic             rise;
    logic             fall;

    assign rise = btn_level & ~level_d;
    assign fall = ~btn_level & level_d;

    // Synchroniser and debouncer: the level flips only after sync2 has
    // disagreed with it for DEBOUNCE consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            db_cnt    <= '0;
            btn_level <= 1'b0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
            if (sync2 == btn_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_level <= ~btn_level;
                db_cnt    <= '0;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
        end
    end

    // Registered edge pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_d     <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            level_d     <= btn_level;
            btn_press   <= rise;
            btn_release <= fall;
        end
    end

    // Auto-repeat FSM. A debounced fall wins over a coincident terminal
    // count so a release never emits a trailing action pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            rpt_cnt <= '0;
            btn_out <= 1'b0;
        end else begin
            btn_out <= 1'b0;
            if (fall) begin
                state   <= ST_IDLE;
                rpt_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rise) begin
                            btn_out <= 1'b1;
                            rpt_cnt <= '0;
                            if (repeat_en) begin
                                state <= ST_DELAY;
                            end
                        end
                    end
                    ST_DELAY: begin
                        if (rpt_cnt == DLY_LAST) begin
                            btn_out <= 1'b1;
                            state   <= ST_REPEAT;
                            rpt_cnt <= '0;
                        end else begin
                            rpt_cnt <= rpt_cnt + CNT_W'(1);
                        end
                    end
                    ST_REPEAT: begin
                        if (rpt_cnt == RPT_LAST) begin
                            btn_out <= 1'b1;
                            rpt_cnt <= '0;
                        end else begin
                            rpt_cnt <= rpt_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        rpt_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/btn_ctrl_multi.sv
// Multi-channel button front-end for the game controls; one independent btn_channel per button.
// Latency: raw edge to btn_level = DEBOUNCE+2 edges; btn_press/btn_out one edge later.
// Backpressure: none; all outputs are one-cycle pulses or levels, no arbitration between channels.
// Ports: clk, reset (async, active-low), btn_in[N] raw levels,
//        btn_level[N], btn_press[N], btn_release[N], btn_out[N] (press + auto-repeat pulses).
module btn_ctrl_multi
    import btn_pkg::*;
#(
    parameter int           N            = 4,
    parameter int           CNT_W        = 25,
    parameter int           DEBOUNCE     = DEBOUNCE_DEF,
    parameter int           REPEAT_DELAY = REPEAT_DELAY_DEF,
    parameter int           REPEAT_RATE  = REPEAT_RATE_DEF,
    parameter logic [N-1:0] REPEAT_EN    = {N{1'b1}}
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] btn_in,
    output logic [N-1:0] btn_level,
    output logic [N-1:0] btn_press,
    output logic [N-1:0] btn_release,
    output logic [N-1:0] btn_out
);

    for (genvar i = 0; i < N; i++) begin : g_ch
        btn_channel #(
            .CNT_W        (CNT_W),
            .DEBOUNCE     (DEBOUNCE),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE),
            .repeat_en    (REPEAT_EN[i])
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .btn_in      (btn_in[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .btn_out     (btn_out[i])
        );
    end

endmodule

// File: tb/tb_btn_ctrl_multi.sv
// Self-checking bench for btn_ctrl_multi: directed scenarios plus random button activity,
// every cycle compared against a timing model built from debounce run-lengths and
// press-relative repeat arithmetic.
module tb_btn_ctrl_multi;

    localparam int           N   = 4;
    localparam int           D   = 4;
    localparam int           RD  = 10;
    localparam int           RR  = 3;
    localparam logic [N-1:0] EN  = 4'b0111;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] btn_in = '0;
    logic [N-1:0] btn_level, btn_press, btn_release, btn_out;

    btn_ctrl_multi #(
        .N            (N),
        .CNT_W        (8),
        .DEBOUNCE     (D),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR),
        .REPEAT_EN    (EN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_out     (btn_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model state
    logic [N-1:0] p1, p2;       // raw input seen one and two edges ago
    logic [N-1:0] lv, lv1;      // model level after the previous edge and the one before
    int           run [N];      // consecutive edges the synchronised input disagreed with the level
    int           pe  [N];      // edge index of the last press pulse, -1 when not held
    logic [N-1:0] e_lvl, e_prs, e_rel, e_out;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %b expected %b at edge %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        p1 = '0; p2 = '0; lv = '0; lv1 = '0;
        e_lvl = '0; e_prs = '0; e_rel = '0; e_out = '0;
        for (int i = 0; i < N; i++) begin
            run[i] = 0;
            pe[i]  = -1;
        end
    endtask

    task automatic model_edge(input logic [N-1:0] v);
        logic [N-1:0] vs, nl;
        int t;
        vs = p2;
        p2 = p1;
        p1 = v;
        e_prs = lv & ~lv1;
        e_rel = ~lv & lv1;
        nl = lv;
        for (int i = 0; i < N; i++) begin
            if (vs[i] != lv[i]) begin
                run[i]++;
                if (run[i] == D) begin
                    nl[i]  = ~lv[i];
                    run[i] = 0;
                end
            end else begin
                run[i] = 0;
            end
        end
        e_out = '0;
        for (int i = 0; i < N; i++) begin
            if (e_prs[i]) begin
                e_out[i] = 1'b1;
                pe[i]    = cyc;
            end else if (!lv[i]) begin
                pe[i] = -1;
            end else if (pe[i] >= 0 && EN[i]) begin
                t = cyc - pe[i];
                e_out[i] = (t >= RD) && (((t - RD) % RR) == 0);
            end
        end
        lv1   = lv;
        lv    = nl;
        e_lvl = nl;
    endtask

    // One clock edge with input v held across it, then a full model comparison
    task automatic tick(input logic [N-1:0] v);
        btn_in = v;
        @(posedge clk);
        cyc++;
        if (reset) model_edge(v);
        #1;
        chk("model_level",   btn_level,   e_lvl);
        chk("model_press",   btn_press,   e_prs);
        chk("model_release", btn_release, e_rel);
        chk("model_out",     btn_out,     e_out);
    endtask

    // Press v from a quiet state and check the absolute pulse timeline
    task automatic press_seq(input string tag, input logic [N-1:0] v);
        repeat (D + 1) tick(v);
        chk({tag, "_level_pre"}, btn_level & v, '0);
        tick(v);
        chk({tag, "_level_rise"}, btn_level & v, v);
        chk({tag, "_press_early"}, btn_press, '0);
        tick(v);
        chk({tag, "_press"}, btn_press, v);
        chk({tag, "_out_press"}, btn_out, v);
        repeat (RD - 1) tick(v);
        chk({tag, "_out_gap"}, btn_out, '0);
        tick(v);
        chk({tag, "_rpt1"}, btn_out, v & EN);
        tick(v);
        chk({tag, "_rpt1_end"}, btn_out, '0);
        tick(v);
        tick(v);
        chk({tag, "_rpt2"}, btn_out, v & EN);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_out3, cnt_coinc3, f_edge, s_edge;
        logic bounce_seen;
        logic [N-1:0] rv;
        int rem [N];

        model_reset();
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_level",   btn_level,   '0);
        chk("reset_press",   btn_press,   '0);
        chk("reset_release", btn_release, '0);
        chk("reset_out",     btn_out,     '0);
        reset = 1'b1;
        repeat (4) tick('0);

        // 1. Clean press on channel 0
        press_seq("s1", 4'b0001);

        // 2. Bounce on channel 1 while channel 0 stays held
        bounce_seen = 1'b0;
        for (int k = 0; k < 18; k++) begin
            tick((k < 8 && ((k / 2) % 2 == 0)) ? 4'b0011 : 4'b0001);
            if (btn_level[1] || btn_press[1] || btn_out[1] || btn_release[1]) bounce_seen = 1'b1;
        end
        chk("s2_bounce_quiet", {3'b0, bounce_seen}, '0);

        // 3. Channel 3 without auto-repeat: exactly one action pulse, with the press
        cnt_out3 = 0;
        cnt_coinc3 = 0;
        for (int k = 0; k < 40; k++) begin
            tick(4'b1001);
            if (btn_out[3]) cnt_out3++;
            if (btn_out[3] && btn_press[3]) cnt_coinc3++;
        end
        chk("s3_out_count", N'(cnt_out3), N'(1));
        chk("s3_out_with_press", N'(cnt_coinc3), N'(1));
        repeat (D + 2) tick(4'b0001);
        chk("s3_release_early", btn_release & 4'b1000, '0);
        tick(4'b0001);
        chk("s3_release", btn_release & 4'b1000, 4'b1000);
        tick(4'b0001);
        chk("s3_release_once", btn_release & 4'b1000, '0);

        // 4. Channel 0 release landing on a repeat terminal count
        f_edge = pe[0] + RD;
        while (f_edge < cyc + D + 3) f_edge += RR;
        s_edge = f_edge - D - 2;
        while (cyc + 1 < s_edge) tick(4'b0001);
        while (cyc < f_edge) tick(4'b0000);
        chk("s4_no_out_on_fall", btn_out, '0);
        chk("s4_release", btn_release, 4'b0001);
        repeat (8) tick(4'b0000);
        chk("s4_idle_quiet", btn_out, '0);
        press_seq("s4_repress", 4'b0001);

        // 5. Simultaneous press on all channels
        repeat (D + 6) tick(4'b0000);
        press_seq("s5", 4'b1111);
        repeat (2) tick(4'b1111);

        // 6. Asynchronous reset while channel 0 repeats
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("s6_async_level", btn_level,   '0);
        chk("s6_async_press", btn_press,   '0);
        chk("s6_async_rel",   btn_release, '0);
        chk("s6_async_out",   btn_out,     '0);
        @(posedge clk); cyc++;
        @(posedge clk); cyc++;
        #1;
        chk("s6_hold_level", btn_level, '0);
        chk("s6_hold_out",   btn_out,   '0);
        reset = 1'b1;
        press_seq("s6_after_reset", 4'b1111);

        // Random activity: independent per-channel hold lengths, glitches included
        rv = '0;
        for (int i = 0; i < N; i++) rem[i] = 1;
        for (int k = 0; k < 900; k++) begin
            for (int i = 0; i < N; i++) begin
                rem[i]--;
                if (rem[i] == 0) begin
                    rv[i]  = ~rv[i];
                    rem[i] = int'($urandom_range(1, 30));
                end
            end
            tick(rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
